bayer_mosaic_tx: RTL and testbench
==================================

Name: bayer_mosaic_tx

Overview:
- Transmit end of the raw Bayer video interface consumed by the demosaic stage.
- Accepts RGB pixels over a valid/ready stream and buffers them in a 4-entry FIFO.
- Generates frame timing (vsync/hsync/den) and samples one colour per pixel according to the Bayer phase, emitting 8-bit raw.
- Used as the sensor-model source in sim and for loopback: mosaic -> CFA -> compare.

Parameters:
- H_ACTIVE, 512, active pixels per line
- H_BLANK, 16, blank cycles after each active line (hsync low)
- V_ACTIVE, 512, active lines per frame
- V_BLANK, 4, blank lines between frames (vsync low); each lasts H_ACTIVE+H_BLANK cycles
- BAYER_PATTERN, 0, 2-bit phase at pixel (0,0): 0=RGGB, 1=GRBG, 2=GBRG, 3=BGGR

Ports:
- clk  in  1  pixel clock
- reset  in  1  asynchronous, active-high reset
- enable  in  1  start/continue frame generation
- in_valid  in  1  RGB pixel valid
- in_ready  out  1  FIFO can accept; equals FIFO not full
- in_R  in  8  red
- in_G  in  8  green
- in_B  in  8  blue
- out_vsync  out  1  high for all cycles of active lines
- out_hsync  out  1  high during active pixels of active lines
- out_den  out  1  pixel valid; identical to out_hsync
- out_raw  out  8  Bayer sample; 8'h00 when out_den low
- frame_done  out  1  one-cycle pulse on the last active pixel of a frame
- underrun  out  1  sticky; set when a pixel was due and the FIFO was empty

Behaviour:
- Reset (async, active-high): state IDLE, FIFO empty, counters 0, all outputs 0 (in_ready becomes 1 in the first cycle after reset release).
- FIFO:
  - 4 entries x 24 bits.
  - Write when in_valid & in_ready; read when an active pixel is emitted and the FIFO is not empty.
  - Simultaneous read+write while full is not allowed: in_ready is low when full, regardless of a pending read.
  - Simultaneous read+write while empty: write only; the pixel counts as an underrun.
- Counters:
  - h_cnt runs 0..H_ACTIVE+H_BLANK-1.
  - v_cnt runs 0..V_ACTIVE+V_BLANK-1.
  - Both are 12 bits and wrap to 0 at their terminal values.
- FSM states:
  - IDLE: counters held at 0, outputs low. Go to ACTIVE when enable=1.
  - ACTIVE (v_cnt<V_ACTIVE): h_cnt<H_ACTIVE is an active pixel, otherwise hblank.
  - VBLANK (v_cnt>=V_ACTIVE): vsync low. At the last VBLANK cycle, go to ACTIVE if enable=1, else IDLE.
  - enable dropping mid-frame has no effect until the current frame, including its VBLANK, completes.
- Outputs are registered with 1-cycle latency from the internal counters.
  - out_vsync = (state ACTIVE).
  - out_hsync = out_den = ACTIVE & h_cnt<H_ACTIVE.
- Bayer select:
  - Index p = {v_cnt[0]^BAYER_PATTERN[1], h_cnt[0]^BAYER_PATTERN[0]}.
  - p=00 -> R, 01 -> G, 10 -> G, 11 -> B, taken from the FIFO head.
  - Sample uses line and pixel indices within the active region only.
- Underrun: when an active pixel is due with the FIFO empty, out_raw=8'h00, timing continues uninterrupted, and underrun is set. It clears only on reset.
- frame_done is registered and aligned with out_den of pixel (H_ACTIVE-1, V_ACTIVE-1).
- Reset mid-frame: all outputs go to 0 immediately (async), FIFO contents are discarded, and the next frame starts from (0,0).
- No timing stall ever: the block is a master. Upstream must keep the FIFO non-empty.

Test Plan:
- Params H_ACTIVE=4, H_BLANK=2, V_ACTIVE=2, V_BLANK=1, pattern 0. Stream 8 pixels with R=0x10+i, G=0x40+i, B=0x80+i, enable=1 -> raw sequence 10,41,12,43 / 44,85,46,87. hsync high 4 of every 6 cycles; vsync high 12 cycles then low 6; frame_done coincides with raw 87.
- Same stimulus with BAYER_PATTERN=3 -> first line B,G,B,G = 80,41,82,43; second line G,R,G,R = 44,15,46,17.
- Hold in_valid=0 through the first frame -> out_raw=00 on every den cycle, underrun=1 from the first active cycle and stays 1, timing identical to the first test.
- Hold in_valid=1 with no frame running (enable=0) -> in_ready drops after exactly 4 accepts. After enable=1 the FIFO drains and in_ready returns high.
- Deassert enable mid-line 0 -> frame completes both lines plus VBLANK, then IDLE with all outputs 0. Reassert enable -> the new frame starts at (0,0).
- Assert reset mid-line -> outputs 0 in the same cycle (async), FIFO empty, underrun cleared. After release with enable=1 the first raw sample is from pixel (0,0).

Source files
------------

// File: rtl/bayer_mosaic_tx.sv
// Raw Bayer video source: buffers RGB pixels in a 4-deep FIFO and emits one
// colour sample per pixel under self-generated vsync/hsync/den frame timing.
module bayer_mosaic_tx #(
  parameter int         H_ACTIVE      = 512,
  parameter int         H_BLANK       = 16,
  parameter int         V_ACTIVE      = 512,
  parameter int         V_BLANK       = 4,
  parameter logic [1:0] BAYER_PATTERN = 2'd0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_R,
  input  logic [7:0] in_G,
  input  logic [7:0] in_B,
  output logic       out_vsync,
  output logic       out_hsync,
  output logic       out_den,
  output logic [7:0] out_raw,
  output logic       frame_done,
  output logic       underrun
);

  localparam logic [11:0] H_ACT  = 12'(H_ACTIVE);
  localparam logic [11:0] V_ACT  = 12'(V_ACTIVE);
  localparam logic [11:0] H_LAST = 12'(H_ACTIVE + H_BLANK - 1);
  localparam logic [11:0] V_LAST = 12'(V_ACTIVE + V_BLANK - 1);

  typedef enum logic [1:0] {IDLE, ACTIVE, VBLANK} state_t;

  state_t      state;
  logic [11:0] h_cnt;
  logic [11:0] v_cnt;

  logic [23:0] mem [4];
  logic [1:0]  wr_ptr;
  logic [1:0]  rd_ptr;
  logic [2:0]  count;
  logic [2:0]  count_next;

  logic        pix_due;
  logic        fifo_empty;
  logic        wr_en;
  logic        rd_en;
  logic [23:0] head;
  logic [1:0]  phase;
  logic [7:0]  sample;

  always_comb begin
    pix_due    = (state == ACTIVE) && (h_cnt < H_ACT);
    fifo_empty = (count == 3'd0);
    wr_en      = in_valid && in_ready;
    // An empty FIFO never pops, so a same-cycle write lands and the pixel is lost.
    rd_en      = pix_due && !fifo_empty;
    count_next = count + {2'b00, wr_en} - {2'b00, rd_en};
    head       = mem[rd_ptr];
    phase      = {v_cnt[0] ^ BAYER_PATTERN[1], h_cnt[0] ^ BAYER_PATTERN[0]};
    case (phase)
      2'b00:   sample = head[23:16];
      2'b11:   sample = head[7:0];
      default: sample = head[15:8];
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= {in_R, in_G, in_B};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= 2'd0;
      rd_ptr   <= 2'd0;
      count    <= 3'd0;
      in_ready <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 2'd1;
      if (rd_en) rd_ptr <= rd_ptr + 2'd1;
      count    <= count_next;
      in_ready <= (count_next != 3'd4);
    end
  end

  // Frame FSM; every output is registered one cycle behind the counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      h_cnt      <= 12'd0;
      v_cnt      <= 12'd0;
      out_vsync  <= 1'b0;
      out_hsync  <= 1'b0;
      out_den    <= 1'b0;
      out_raw    <= 8'h00;
      frame_done <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      out_vsync  <= (state == ACTIVE);
      out_hsync  <= pix_due;
      out_den    <= pix_due;
      out_raw    <= rd_en ? sample : 8'h00;
      frame_done <= pix_due && (h_cnt == H_ACT - 12'd1) && (v_cnt == V_ACT - 12'd1);
      if (pix_due && fifo_empty) underrun <= 1'b1;

      case (state)
        IDLE: begin
          h_cnt <= 12'd0;
          v_cnt <= 12'd0;
          if (enable) state <= ACTIVE;
        end
        default: begin
          if (h_cnt == H_LAST) begin
            h_cnt <= 12'd0;
            if (v_cnt == V_LAST) begin
              // enable is only consulted at the frame boundary
              v_cnt <= 12'd0;
              state <= enable ? ACTIVE : IDLE;
            end else begin
              v_cnt <= v_cnt + 12'd1;
              if (v_cnt == V_ACT - 12'd1) state <= VBLANK;
            end
          end else begin
            h_cnt <= h_cnt + 12'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bayer_mosaic_tx.sv
// Bench for bayer_mosaic_tx: two instances (RGGB and BGGR) share stimulus and
// are checked every cycle against a frame-position/queue reference model.
module tb_bayer_mosaic_tx;

  localparam int HA = 4;
  localparam int HB = 2;
  localparam int VA = 2;
  localparam int VB = 1;
  localparam int HT = HA + HB;
  localparam int FT = (VA + VB) * HT;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic enable = 1'b0;
  logic in_valid = 1'b0;
  logic [7:0] in_R = 8'h00;
  logic [7:0] in_G = 8'h00;
  logic [7:0] in_B = 8'h00;

  logic ready0, vsync0, hsync0, den0, fd0, under0;
  logic ready3, vsync3, hsync3, den3, fd3, under3;
  logic [7:0] raw0, raw3;

  always #5 clk = ~clk;

  bayer_mosaic_tx #(.H_ACTIVE(HA), .H_BLANK(HB), .V_ACTIVE(VA), .V_BLANK(VB),
                    .BAYER_PATTERN(2'd0)) dut0 (
    .clk(clk), .reset(reset), .enable(enable), .in_valid(in_valid),
    .in_ready(ready0), .in_R(in_R), .in_G(in_G), .in_B(in_B),
    .out_vsync(vsync0), .out_hsync(hsync0), .out_den(den0), .out_raw(raw0),
    .frame_done(fd0), .underrun(under0));

  bayer_mosaic_tx #(.H_ACTIVE(HA), .H_BLANK(HB), .V_ACTIVE(VA), .V_BLANK(VB),
                    .BAYER_PATTERN(2'd3)) dut3 (
    .clk(clk), .reset(reset), .enable(enable), .in_valid(in_valid),
    .in_ready(ready3), .in_R(in_R), .in_G(in_G), .in_B(in_B),
    .out_vsync(vsync3), .out_hsync(hsync3), .out_den(den3), .out_raw(raw3),
    .frame_done(fd3), .underrun(under3));

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
    total++;
    if (got !== expv) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h at t=%0t", name, got, expv, $time);
    end
  endtask

  // Reference model: frame position as a flat index, FIFO as a queue.
  logic [23:0] fq[$];
  bit       m_running = 0;
  int       m_t = 0;
  bit       exp_vsync = 0, exp_den = 0, exp_fd = 0, exp_under = 0, exp_ready = 0;
  bit [7:0] exp_raw0 = 0, exp_raw3 = 0;

  function automatic logic [7:0] bayer(input int pat, input int line, input int col,
                                       input logic [23:0] px);
    int p;
    p = (((line % 2) ^ (pat / 2)) * 2) + ((col % 2) ^ (pat % 2));
    case (p)
      0:       return px[23:16];
      3:       return px[7:0];
      default: return px[15:8];
    endcase
  endfunction

  always @(posedge clk or posedge reset) begin
    int line, col;
    bit active, empty, push;
    logic [23:0] hd;
    if (reset) begin
      fq.delete();
      m_running = 0; m_t = 0;
      exp_vsync = 0; exp_den = 0; exp_fd = 0; exp_under = 0; exp_ready = 0;
      exp_raw0 = 0; exp_raw3 = 0;
    end else begin
      line   = m_t / HT;
      col    = m_t % HT;
      active = m_running && line < VA && col < HA;
      empty  = (fq.size() == 0);
      hd     = empty ? 24'h0 : fq[0];
      push   = in_valid && exp_ready;
      exp_vsync = m_running && line < VA;
      exp_den   = active;
      exp_raw0  = (active && !empty) ? bayer(0, line, col, hd) : 8'h00;
      exp_raw3  = (active && !empty) ? bayer(3, line, col, hd) : 8'h00;
      exp_fd    = active && line == VA - 1 && col == HA - 1;
      if (active && empty) exp_under = 1;
      if (active && !empty) void'(fq.pop_front());
      if (push) fq.push_back({in_R, in_G, in_B});
      exp_ready = fq.size() < 4;
      if (!m_running) begin
        if (enable) begin m_running = 1; m_t = 0; end
      end else begin
        m_t++;
        if (m_t == FT) begin m_t = 0; m_running = enable; end
      end
    end
  end

  // Per-cycle compare plus captures for the literal expectations.
  bit       chk = 0;
  logic [7:0] cap0[$], cap3[$];
  int       hs_cnt = 0, vs_cnt = 0, fd_cnt = 0;
  logic [7:0] fd_raw0 = 8'h00;

  always @(negedge clk) begin
    if (chk) begin
      check("vsync0", 32'(vsync0), 32'(exp_vsync));
      check("hsync0", 32'(hsync0), 32'(exp_den));
      check("den0",   32'(den0),   32'(exp_den));
      check("raw0",   32'(raw0),   32'(exp_raw0));
      check("fd0",    32'(fd0),    32'(exp_fd));
      check("under0", 32'(under0), 32'(exp_under));
      check("ready0", 32'(ready0), 32'(exp_ready));
      check("vsync3", 32'(vsync3), 32'(exp_vsync));
      check("den3",   32'(den3),   32'(exp_den));
      check("raw3",   32'(raw3),   32'(exp_raw3));
      check("fd3",    32'(fd3),    32'(exp_fd));
      check("ready3", 32'(ready3), 32'(exp_ready));
      if (den0) cap0.push_back(raw0);
      if (den3) cap3.push_back(raw3);
      if (hsync0) hs_cnt++;
      if (vsync0) vs_cnt++;
      if (fd0) begin fd_cnt++; fd_raw0 = raw0; end
    end
  end

  // Stimulus driver: mode 0 = counted pixel ramp, mode 1 = random pixels.
  int mode = 0, idx = 0, limit = 0, acc_cnt = 0;
  bit stream_on = 0, acc = 0;
  logic [23:0] cur = 24'h0;

  task automatic step();
    @(negedge clk);
    if (acc) begin
      idx++;
      cur = 24'($urandom);
    end
    if (mode == 0) begin
      in_valid = stream_on && idx < limit;
      in_R = 8'(16 + idx);
      in_G = 8'(64 + idx);
      in_B = 8'(128 + idx);
    end else begin
      in_valid = stream_on && ($urandom_range(0, 9) < 8);
      {in_R, in_G, in_B} = cur;
    end
    acc = in_valid && ready0 && !reset;
    if (acc) acc_cnt++;
  endtask

  task automatic clear_caps();
    cap0.delete(); cap3.delete();
    hs_cnt = 0; vs_cnt = 0; fd_cnt = 0; fd_raw0 = 8'h00;
  endtask

  logic [7:0] lit0 [8] = '{8'h10, 8'h41, 8'h12, 8'h43, 8'h44, 8'h85, 8'h46, 8'h87};
  logic [7:0] lit3 [8] = '{8'h80, 8'h41, 8'h82, 8'h43, 8'h44, 8'h15, 8'h46, 8'h17};

  initial begin
    int nz;
    #1 reset = 1'b1;
    repeat (2) step();
    chk = 1;
    check("reset_ready", 32'(ready0), 32'd0);
    check("reset_vsync", 32'(vsync0), 32'd0);
    step();
    #2 reset = 1'b0;
    step();
    check("ready_after_release", 32'(ready0), 32'd1);

    // Ramp stream: fill with no frame running, then one frame.
    clear_caps();
    mode = 0; idx = 0; limit = 8; stream_on = 1; acc_cnt = 0;
    repeat (8) step();
    check("fill_accepts", 32'(acc_cnt), 32'd4);
    check("fill_ready_low", 32'(ready0), 32'd0);
    enable = 1'b1;
    repeat (3) step();
    enable = 1'b0;
    repeat (30) step();
    check("ramp_count0", 32'(cap0.size()), 32'd8);
    check("ramp_count3", 32'(cap3.size()), 32'd8);
    for (int i = 0; i < 8; i++) begin
      if (i < cap0.size()) check($sformatf("ramp_raw0_%0d", i), 32'(cap0[i]), 32'(lit0[i]));
      if (i < cap3.size()) check($sformatf("ramp_raw3_%0d", i), 32'(cap3[i]), 32'(lit3[i]));
    end
    check("ramp_hsync_cycles", 32'(hs_cnt), 32'd8);
    check("ramp_vsync_cycles", 32'(vs_cnt), 32'd12);
    check("ramp_fd_count", 32'(fd_cnt), 32'd1);
    check("ramp_fd_raw", 32'(fd_raw0), 32'h87);
    check("ramp_drained_ready", 32'(ready0), 32'd1);
    check("ramp_no_underrun", 32'(under0), 32'd0);

    // Starved frame: no input at all.
    clear_caps();
    stream_on = 0;
    enable = 1'b1;
    repeat (5) step();
    enable = 1'b0;
    repeat (25) step();
    nz = 0;
    foreach (cap0[i]) if (cap0[i] != 8'h00) nz++;
    check("starve_den_cycles", 32'(cap0.size()), 32'd8);
    check("starve_nonzero_raw", 32'(nz), 32'd0);
    check("starve_underrun", 32'(under0), 32'd1);
    check("starve_vsync_cycles", 32'(vs_cnt), 32'd12);

    // Reset in the middle of a line.
    mode = 1; stream_on = 1; enable = 1'b1;
    repeat (10) step();
    #2 reset = 1'b1;
    in_valid = 1'b0; acc = 0; stream_on = 0;
    #1;
    check("midrst_vsync", 32'(vsync0), 32'd0);
    check("midrst_den", 32'(den0), 32'd0);
    check("midrst_raw", 32'(raw0), 32'd0);
    check("midrst_fd", 32'(fd0), 32'd0);
    check("midrst_underrun", 32'(under0), 32'd0);
    check("midrst_ready", 32'(ready0), 32'd0);
    step();
    #2 reset = 1'b0;
    enable = 1'b0;
    cur = 24'hA1B2C3;
    clear_caps();
    stream_on = 1;
    repeat (6) step();
    enable = 1'b1;
    repeat (12) step();
    check("post_rst_has_pixels", 32'(cap0.size() > 0 && cap3.size() > 0), 32'd1);
    if (cap0.size() > 0) check("post_rst_first_raw0", 32'(cap0[0]), 32'hA1);
    if (cap3.size() > 0) check("post_rst_first_raw3", 32'(cap3[0]), 32'hC3);

    // Random traffic with enable toggling.
    for (int k = 0; k < 12; k++) begin
      enable = ($urandom_range(0, 3) != 0);
      repeat (20) step();
    end
    enable = 1'b0;
    repeat (25) step();

    chk = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
